// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong geometry, derived limits and game state encoding
//
// Purpose: the one source of screen and object geometry. The game engine and
// the renderer both import it, so the two always agree on sizes and positions.
// Ports: none (package).
package pong_pkg;

  // Screen and object geometry (pixels)
  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;
  localparam int BALL_SIZE     = 10;
  localparam int PADDLE_WIDTH  = 10;
  localparam int PADDLE_HEIGHT = 60;
  localparam int PADDLEL_X     = 3;
  localparam int PADDLER_X     = 630;

  // Derived limits
  localparam int PADDLE_Y_MAX   = SCREEN_H - PADDLE_HEIGHT;        // 420
  localparam int BALL_Y_MAX     = SCREEN_H - BALL_SIZE;            // 470
  localparam int BALL_X_CENTRE  = (SCREEN_W - BALL_SIZE) / 2;      // 315
  localparam int BALL_Y_CENTRE  = (SCREEN_H - BALL_SIZE) / 2;      // 235
  localparam int PADDLE_Y_RESET = (SCREEN_H - PADDLE_HEIGHT) / 2;  // 210

  // Ball x positions that sit flush against each paddle face
  localparam int PADDLEL_HIT_X  = PADDLEL_X + PADDLE_WIDTH;        // 13
  localparam int PADDLER_HIT_X  = PADDLER_X - BALL_SIZE;           // 620

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } pong_state_e;

endpackage

// File: rtl/pong_paddle.sv
// rtl/pong_paddle.sv - one paddle: saturating per-frame move clamped to 0..420
//
// Purpose: holds a paddle's top y and steps it by SPEED on each enabled tick.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick_i     : advance enable (one cycle per accepted frame tick)
//   up_i, dn_i : move request; both or neither means hold
//   y_o        : registered top of the paddle
module pong_paddle
  import pong_pkg::*;
#(
  parameter int SPEED = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       up_i,
  input  logic       dn_i,
  output logic [9:0] y_o
);

  localparam logic [9:0] SPD   = 10'(SPEED);
  localparam logic [9:0] Y_MAX = 10'(PADDLE_Y_MAX);
  localparam logic [9:0] Y_RST = 10'(PADDLE_Y_RESET);

  logic [9:0] y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (tick_i && up_i && !dn_i) begin
      y_d = (y_q < SPD) ? 10'd0 : y_q - SPD;
    end else if (tick_i && dn_i && !up_i) begin
      // Compare before adding so the sum can never pass the clamp.
      y_d = (y_q > Y_MAX - SPD) ? Y_MAX : y_q + SPD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= Y_RST;
    else        y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/pong_game_state.sv
// rtl/pong_game_state.sv - frame-rate Pong engine: ball, paddles, scores, win flags
//
// Purpose: advances the game once per frame_tick; every output is a register,
// so the renderer sees values that are stable for a whole frame.
// Optional feature: define PONG_RIGHT_AI_EN to drive the right paddle from the
// ball position instead of btnR_up/btnR_dn.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   frame_tick              : one pulse per frame (vblank start)
//   start                   : starts a game from IDLE or OVER
//   btnL_up/dn, btnR_up/dn  : player buttons, synchronised, level-sensitive
//   ball_x, ball_y          : top-left of the 10x10 ball
//   paddleL_y, paddleR_y    : top of each 60-pixel paddle
//   scoreL, scoreR          : points
//   game_over, left_win, right_win : end-of-game flags
module pong_game_state
  import pong_pkg::*;
#(
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_SPEED = 6,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btnL_up,
  input  logic       btnL_dn,
  input  logic       btnR_up,
  input  logic       btnR_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddleL_y,
  output logic [9:0] paddleR_y,
  output logic [2:0] scoreL,
  output logic [2:0] scoreR,
  output logic       game_over,
  output logic       left_win,
  output logic       right_win
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  // Every coordinate sum below stays under 1024, so 10 bits are enough.
  localparam logic [9:0] BS       = 10'(BALL_SPEED);
  localparam logic [9:0] BSIZE    = 10'(BALL_SIZE);
  localparam logic [9:0] PH       = 10'(PADDLE_HEIGHT);
  localparam logic [9:0] BY_MAX   = 10'(BALL_Y_MAX);
  localparam logic [9:0] X_CTR    = 10'(BALL_X_CENTRE);
  localparam logic [9:0] Y_CTR    = 10'(BALL_Y_CENTRE);
  localparam logic [9:0] L_HIT    = 10'(PADDLEL_HIT_X);
  localparam logic [9:0] R_HIT    = 10'(PADDLER_HIT_X);
  localparam logic [9:0] R_FACE   = 10'(PADDLER_X);
  localparam logic [2:0] WIN3     = 3'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);

  pong_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic             dir_r_q, dir_r_d;   // 1: moving right
  logic             dir_d_q, dir_d_d;   // 1: moving down
  logic [2:0]       score_l_q, score_l_d, score_r_q, score_r_d;
  logic             over_q, over_d, lwin_q, lwin_d, rwin_q, rwin_d;

  logic       start_ok, tick_en;
  logic       r_up, r_dn;
  logic [9:0] pad_l, pad_r;

  // An accepted start swallows a coincident tick, paddles included.
  assign start_ok = start && (state_q == IDLE || state_q == OVER);
  assign tick_en  = frame_tick && !start_ok;

`ifdef PONG_RIGHT_AI_EN
  logic       unused_btn_r;
  logic [9:0] ball_ctr, pad_r_ctr;
  assign unused_btn_r = btnR_up ^ btnR_dn;
  assign ball_ctr     = ball_y_q + (BSIZE >> 1);
  assign pad_r_ctr    = pad_r + (PH >> 1);
  assign r_up         = ball_ctr < pad_r_ctr;
  assign r_dn         = ball_ctr > pad_r_ctr;
`else
  assign r_up = btnR_up;
  assign r_dn = btnR_dn;
`endif

  pong_paddle #(.SPEED(PADDLE_SPEED)) u_paddle_l (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick_en),
    .up_i   (btnL_up),
    .dn_i   (btnL_dn),
    .y_o    (pad_l)
  );

  pong_paddle #(.SPEED(PADDLE_SPEED)) u_paddle_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick_en),
    .up_i   (r_up),
    .dn_i   (r_dn),
    .y_o    (pad_r)
  );

  logic [9:0] nx, ny;
  logic       ndr, ndd, ovl_l, ovl_r, pt_l, pt_r;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dir_r_d   = dir_r_q;
    dir_d_d   = dir_d_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    over_d    = over_q;
    lwin_d    = lwin_q;
    rwin_d    = rwin_q;

    // Candidate ball move, from this frame's registered ball and paddles.
    ny  = ball_y_q;
    ndd = dir_d_q;
    if (dir_d_q) begin
      if (ball_y_q + BS > BY_MAX) begin
        ny  = BY_MAX;
        ndd = 1'b0;
      end else begin
        ny = ball_y_q + BS;
      end
    end else begin
      if (ball_y_q < BS) begin
        ny  = 10'd0;
        ndd = 1'b1;
      end else begin
        ny = ball_y_q - BS;
      end
    end

    ovl_l = (ball_y_q + BSIZE > pad_l) && (ball_y_q < pad_l + PH);
    ovl_r = (ball_y_q + BSIZE > pad_r) && (ball_y_q < pad_r + PH);

    nx   = ball_x_q;
    ndr  = dir_r_q;
    pt_l = 1'b0;
    pt_r = 1'b0;
    // Hit test comes first so a ball the paddle can reach never scores.
    if (!dir_r_q) begin
      if (ball_x_q < L_HIT + BS && ovl_l) begin
        nx  = L_HIT;
        ndr = 1'b1;
      end else if (ball_x_q < BS) begin
        pt_r = 1'b1;
      end else begin
        nx = ball_x_q - BS;
      end
    end else begin
      if (ball_x_q + BSIZE + BS > R_FACE && ovl_r) begin
        nx  = R_HIT;
        ndr = 1'b0;
      end else if (ball_x_q + BS > R_FACE) begin
        pt_l = 1'b1;
      end else begin
        nx = ball_x_q + BS;
      end
    end

    if (start_ok) begin
      state_d   = SERVE;
      cnt_d     = SERVE_LOAD;
      ball_x_d  = X_CTR;
      ball_y_d  = Y_CTR;
      dir_r_d   = 1'b1;
      dir_d_d   = 1'b1;
      score_l_d = 3'd0;
      score_r_d = 3'd0;
      over_d    = 1'b0;
      lwin_d    = 1'b0;
      rwin_d    = 1'b0;
    end else if (frame_tick) begin
      unique case (state_q)
        SERVE: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = PLAY;
        end
        PLAY: begin
          if (pt_l || pt_r) begin
            if (pt_l) score_l_d = score_l_q + 3'd1;
            else      score_r_d = score_r_q + 3'd1;
            if ((pt_l && score_l_q + 3'd1 == WIN3) ||
                (pt_r && score_r_q + 3'd1 == WIN3)) begin
              // Ball stays where it was when the deciding point was lost.
              state_d = OVER;
              over_d  = 1'b1;
              lwin_d  = pt_l;
              rwin_d  = pt_r;
            end else begin
              // Serve toward whoever conceded.
              state_d  = SERVE;
              cnt_d    = SERVE_LOAD;
              ball_x_d = X_CTR;
              ball_y_d = Y_CTR;
              dir_r_d  = pt_l;
              dir_d_d  = 1'b1;
            end
          end else begin
            ball_x_d = nx;
            ball_y_d = ny;
            dir_r_d  = ndr;
            dir_d_d  = ndd;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ball_x_q  <= X_CTR;
      ball_y_q  <= Y_CTR;
      dir_r_q   <= 1'b1;
      dir_d_q   <= 1'b1;
      score_l_q <= 3'd0;
      score_r_q <= 3'd0;
      over_q    <= 1'b0;
      lwin_q    <= 1'b0;
      rwin_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dir_r_q   <= dir_r_d;
      dir_d_q   <= dir_d_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      over_q    <= over_d;
      lwin_q    <= lwin_d;
      rwin_q    <= rwin_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign paddleL_y = pad_l;
  assign paddleR_y = pad_r;
  assign scoreL    = score_l_q;
  assign scoreR    = score_r_q;
  assign game_over = over_q;
  assign left_win  = lwin_q;
  assign right_win = rwin_q;

endmodule

// File: tb/tb_pong_game_state.sv
// tb/tb_pong_game_state.sv - scoreboard bench for pong_game_state against a behavioural game model
module tb_pong_game_state;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0;
  logic       btnL_up = 1'b0, btnL_dn = 1'b0, btnR_up = 1'b0, btnR_dn = 1'b0;
  logic [9:0] ball_x, ball_y, paddleL_y, paddleR_y;
  logic [2:0] scoreL, scoreR;
  logic       game_over, left_win, right_win;

  pong_game_state dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .btnL_up    (btnL_up),
    .btnL_dn    (btnL_dn),
    .btnR_up    (btnR_up),
    .btnR_dn    (btnR_dn),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddleL_y  (paddleL_y),
    .paddleR_y  (paddleR_y),
    .scoreL     (scoreL),
    .scoreR     (scoreR),
    .game_over  (game_over),
    .left_win   (left_win),
    .right_win  (right_win)
  );

  always #5 clk = ~clk;

  logic [48:0] dut_vec;
  assign dut_vec = {ball_x, ball_y, paddleL_y, paddleR_y, scoreL, scoreR,
                    game_over, left_win, right_win};

  localparam logic [48:0] RESET_VEC = {10'd315, 10'd235, 10'd210, 10'd210, 3'd0, 3'd0, 3'b000};

  int n_vec = 0;
  int n_err = 0;
  logic [48:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural game model: state 0 IDLE, 1 SERVE, 2 PLAY, 3 OVER
  int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_cnt;
  bit m_dr, m_dd, m_go, m_lw, m_rw;

  function automatic logic [48:0] model_vec();
    return {10'(m_bx), 10'(m_by), 10'(m_pl), 10'(m_pr), 3'(m_sl), 3'(m_sr), m_go, m_lw, m_rw};
  endfunction

  task automatic model_reset();
    m_bx = 315; m_by = 235; m_pl = 210; m_pr = 210;
    m_sl = 0; m_sr = 0; m_st = 0; m_cnt = 0;
    m_dr = 1; m_dd = 1; m_go = 0; m_lw = 0; m_rw = 0;
  endtask

  task automatic model_start();
    m_sl = 0; m_sr = 0; m_go = 0; m_lw = 0; m_rw = 0;
    m_st = 1; m_cnt = 60; m_bx = 315; m_by = 235; m_dr = 1; m_dd = 1;
  endtask

  function automatic int pad_move(int y, bit u, bit d);
    if (u && !d) return (y - 6 < 0) ? 0 : y - 6;
    if (d && !u) return (y + 6 > 420) ? 420 : y + 6;
    return y;
  endfunction

  task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd);
    int npl, npr, nx, ny, scorer;
    bit ndr, ndd, hit_l, hit_r;
    npl = pad_move(m_pl, lu, ld);
`ifdef PONG_RIGHT_AI_EN
    ru = (m_by + 5 < m_pr + 30);
    rd = (m_by + 5 > m_pr + 30);
`endif
    npr = pad_move(m_pr, ru, rd);
    if (m_st == 1) begin
      m_cnt--;
      if (m_cnt == 0) m_st = 2;
    end else if (m_st == 2) begin
      ndd = m_dd;
      if (m_dd) begin
        if (m_by + 4 > 470) begin ny = 470; ndd = 0; end else ny = m_by + 4;
      end else begin
        if (m_by < 4) begin ny = 0; ndd = 1; end else ny = m_by - 4;
      end
      hit_l = (m_by + 10 > m_pl) && (m_by < m_pl + 60);
      hit_r = (m_by + 10 > m_pr) && (m_by < m_pr + 60);
      nx = m_bx; ndr = m_dr; scorer = 0;
      if (!m_dr) begin
        if (m_bx < 17 && hit_l) begin nx = 13; ndr = 1; end
        else if (m_bx < 4) scorer = 2;
        else nx = m_bx - 4;
      end else begin
        if (m_bx + 14 > 630 && hit_r) begin nx = 620; ndr = 0; end
        else if (m_bx + 4 > 630) scorer = 1;
        else nx = m_bx + 4;
      end
      if (scorer == 0) begin
        m_bx = nx; m_by = ny; m_dr = ndr; m_dd = ndd;
      end else begin
        if (scorer == 1) m_sl++; else m_sr++;
        if (m_sl == 5 || m_sr == 5) begin
          m_st = 3; m_go = 1; m_lw = (scorer == 1); m_rw = (scorer == 2);
        end else begin
          m_st = 1; m_cnt = 60; m_bx = 315; m_by = 235;
          m_dr = (scorer == 1); m_dd = 1;
        end
      end
    end
    m_pl = npl;
    m_pr = npr;
  endtask

  // One driven cycle (tick and/or start) followed by one quiet cycle with the
  // buttons still held; both are predicted and checked.
  task automatic step(input bit ft, input bit st, input bit lu, input bit ld,
                      input bit ru, input bit rd);
    @(negedge clk);
    btnL_up = lu; btnL_dn = ld; btnR_up = ru; btnR_dn = rd;
    frame_tick = ft; start = st;
    if (st && (m_st == 0 || m_st == 3)) model_start();
    else if (ft) model_tick(lu, ld, ru, rd);
    exp_q.push_back(model_vec());
    @(posedge clk); #1;
    frame_tick = 0; start = 0;
    chk("tick", dut_vec, exp_q.pop_front());
    exp_q.push_back(model_vec());
    @(posedge clk); #1;
    chk("hold", dut_vec, exp_q.pop_front());
  endtask

  initial begin
    logic [1:0] r;
    int d, t;
    bit lu, ld, track;

    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("reset", dut_vec, RESET_VEC);
    @(negedge clk) rst_n = 1'b1;

    // Paddle saturation and both-buttons hold, in IDLE
    repeat (10) step(1, 0, 1, 0, 0, 0);
    chk("padL_after_10_up", paddleL_y, 10'd150);
    repeat (3) step(1, 0, 1, 1, 0, 0);
    chk("padL_both_hold", paddleL_y, 10'd150);
    repeat (30) step(1, 0, 1, 0, 0, 0);
    chk("padL_floor", paddleL_y, 10'd0);
    chk("idle_ball", {ball_x, ball_y}, {10'd315, 10'd235});

    // Start coinciding with a tick: the tick must not move the paddle
    step(1, 1, 0, 1, 0, 0);
    chk("start_tick_discard", paddleL_y, 10'd0);

    repeat (60) step(1, 0, 0, 0, 0, 0);
    chk("serve_hold_60", {ball_x, ball_y}, {10'd315, 10'd235});
    step(1, 0, 0, 0, 0, 0);
    chk("first_move_61", {ball_x, ball_y}, {10'd319, 10'd239});

    // Full game: left goes random until it has conceded once, then tracks
    t = 0;
    while (!m_go && t < 8000) begin
`ifdef PONG_RIGHT_AI_EN
      track = 0;
`else
      track = (m_sr >= 1);
`endif
      if (track) begin
        d  = (m_pl + 30) - (m_by + 5);
        lu = (d > 3);
        ld = (d < -3);
      end else begin
        r  = 2'($urandom_range(0, 3));
        lu = r[0];
        ld = r[1];
      end
      r = 2'($urandom_range(0, 3));
      step(1, (t == 100), lu, ld, r[0], r[1]);
      t++;
    end
    chk("game_end", game_over, 1'b1);
    chk("winner_score", (left_win ? scoreL : scoreR), 3'd5);
    chk("one_winner", left_win ^ right_win, 1'b1);

    // OVER: ball frozen, paddles free
    repeat (5) begin
      r = 2'($urandom_range(0, 3));
      step(1, 0, r[0], r[1], r[1], r[0]);
    end

    step(0, 1, 0, 0, 0, 0);
    chk("restart_clear", {scoreL, scoreR, game_over, left_win, right_win}, 9'd0);
    chk("restart_ball", {ball_x, ball_y}, {10'd315, 10'd235});
    repeat (3) step(1, 0, 0, 1, 1, 0);

    // Asynchronous reset in the middle of a cycle
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_vec, RESET_VEC);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(1, 0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
